game_event_scheduler: RTL

- Shares the single KCPSM6 interrupt line between several game event sources: the frame tick, collision detect, button events and the spare timer.
- Latches each event as pending and grants one at a time by round-robin. Drives interrupt and holds it until interrupt_ack. Exposes the granted cause ID and waits for firmware to signal service completion, or for a watchdog to expire.
- Sits between the event producers and the game interface / KCPSM6 interrupt pins.

---
 rtl/game_pkg.sv | 20 ++
 rtl/game_event_scheduler_rr_arbiter.sv | 35 +++
 rtl/game_event_scheduler.sv | 139 +++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game event scheduler: FSM encoding,
// event source indices and the default cause width.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    SERVICE,
    GAP
  } sched_state_t;

  localparam int SRC_FRAME   = 0;
  localparam int SRC_COLLIDE = 1;
  localparam int SRC_BTN     = 2;
  localparam int SRC_TIMER   = 3;

  localparam int DEF_NUM_SRC = 4;
  localparam int CAUSE_W     = $clog2(DEF_NUM_SRC);

endpackage

// File: rtl/game_event_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after ptr,
// wrapping. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int CW      = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] eligible,
  input  logic [CW-1:0]      ptr,
  output logic               grant_valid,
  output logic [CW-1:0]      grant_idx
);

  logic [CW:0]   sum;
  logic [CW-1:0] idx;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    idx         = '0;
    // Walk from the farthest offset down so the nearest eligible index wins.
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (CW + 1)'(k);
      if (sum >= (CW + 1)'(NUM_SRC)) sum = sum - (CW + 1)'(NUM_SRC);
      idx = sum[CW-1:0];
      if (eligible[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/game_event_scheduler.sv
// Multiplexes game event sources onto the single KCPSM6 interrupt line with
// pending/overrun tracking, round-robin grant, service watchdog and gap timer.
module game_event_scheduler
  import game_pkg::*;
#(
  parameter int NUM_SRC  = DEF_NUM_SRC,
  parameter int TICK_DIV = 4,
  parameter int MIN_GAP  = 2,
  parameter int WDOG_CYC = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         evt_in,
  input  logic [NUM_SRC-1:0]         evt_mask,
  input  logic                       interrupt_ack,
  input  logic                       svc_done,
  input  logic                       ovr_clr,
  output logic                       interrupt,
  output logic [$clog2(NUM_SRC)-1:0] cause,
  output logic [NUM_SRC-1:0]         pending,
  output logic [NUM_SRC-1:0]         overrun,
  output logic                       busy,
  output logic                       wdog_err
);

  localparam int CW = $clog2(NUM_SRC);

  sched_state_t       state;
  logic [NUM_SRC-1:0] evt_d;
  logic [NUM_SRC-1:0] evt_edge;
  logic [NUM_SRC-1:0] ev_set;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] grant_clr;
  logic [7:0]         tick_cnt;
  logic               tick_hit;
  logic [CW-1:0]      ptr;
  logic [CW-1:0]      next_ptr;
  logic [CW-1:0]      grant_idx;
  logic               grant_valid;
  logic [15:0]        wdog_cnt;
  logic [3:0]         gap_cnt;

  assign evt_edge = evt_in & ~evt_d;
  assign tick_hit = evt_edge[SRC_FRAME] && (tick_cnt == 8'(TICK_DIV - 1));

  // The frame source only latches on every TICK_DIV-th edge.
  always_comb begin
    ev_set            = evt_edge;
    ev_set[SRC_FRAME] = tick_hit;
  end

  assign eligible  = pending & evt_mask;
  assign grant_clr = (state == IDLE && grant_valid) ? (NUM_SRC'(1) << grant_idx) : '0;
  assign next_ptr  = (cause == CW'(NUM_SRC - 1)) ? '0 : cause + CW'(1);

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .CW      (CW)
  ) u_rr_arbiter (
    .eligible    (eligible),
    .ptr         (ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      evt_d    <= '0;
      tick_cnt <= '0;
      pending  <= '0;
      overrun  <= '0;
    end else begin
      evt_d <= evt_in;
      if (evt_edge[SRC_FRAME]) tick_cnt <= tick_hit ? 8'd0 : tick_cnt + 8'd1;
      // A fresh edge on the source being granted re-arms it without overrun.
      pending <= (pending & ~grant_clr) | ev_set;
      if (ovr_clr) overrun <= '0;
      else         overrun <= overrun | (ev_set & pending & ~grant_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      interrupt <= 1'b0;
      cause     <= '0;
      busy      <= 1'b0;
      wdog_err  <= 1'b0;
      ptr       <= '0;
      wdog_cnt  <= '0;
      gap_cnt   <= '0;
    end else begin
      if (ovr_clr) wdog_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_valid) begin
            cause     <= grant_idx;
            interrupt <= 1'b1;
            busy      <= 1'b1;
            state     <= ASSERT;
          end
        end
        ASSERT: begin
          if (interrupt_ack) begin
            interrupt <= 1'b0;
            wdog_cnt  <= '0;
            state     <= SERVICE;
          end
        end
        SERVICE: begin
          if (svc_done) begin
            ptr     <= next_ptr;
            gap_cnt <= '0;
            state   <= GAP;
          end else if (wdog_cnt == 16'(WDOG_CYC - 1)) begin
            wdog_err <= !ovr_clr;
            ptr      <= next_ptr;
            gap_cnt  <= '0;
            state    <= GAP;
          end else begin
            wdog_cnt <= wdog_cnt + 16'd1;
          end
        end
        GAP: begin
          if (gap_cnt == 4'(MIN_GAP - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
